multicycle_control: RTL and testbench

Sequential successor to the single-cycle opcode decoder. It is a multi-cycle RV32I control FSM that sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK and handshakes with instruction and data memories that have variable latency. It drives the same datapath selects as the single-cycle core, with corrected jal/jalr/branch encodings. It adds illegal-opcode trapping, memory wait timeout, and a retired-instruction counter. It sits between the instruction register and the datapath muxes/enables.

---
 rtl/multicycle_control_if.sv | 43 ++++
 rtl/multicycle_control.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control_if
//  Purpose  : Bundles the opcode/handshake inputs and datapath controls of the
//             multi-cycle RV32I control FSM.
//  Revision : 1.0  initial release
// ============================================================================
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic             branch_comp;
  logic             imem_ready;
  logic             dmem_ready;
  logic             imem_req;
  logic             ir_write;
  logic             dmem_req;
  logic             dmem_write;
  logic             regfile_write;
  logic             pc_write;
  logic [1:0]       pc_next_address_sel;
  logic [2:0]       regfile_data_source_sel;
  logic             imm_alu_sel;
  logic             illegal_insn;
  logic             timeout;
  logic [2:0]       state;
  logic [CNT_W-1:0] instret;

  modport master (
    input  opcode, branch_comp, imem_ready, dmem_ready,
    output imem_req, ir_write, dmem_req, dmem_write, regfile_write, pc_write,
    output pc_next_address_sel, regfile_data_source_sel, imm_alu_sel,
    output illegal_insn, timeout, state, instret
  );

  modport slave (
    output opcode, branch_comp, imem_ready, dmem_ready,
    input  imem_req, ir_write, dmem_req, dmem_write, regfile_write, pc_write,
    input  pc_next_address_sel, regfile_data_source_sel, imm_alu_sel,
    input  illegal_insn, timeout, state, instret
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control
//  Purpose  : Multi-cycle RV32I control FSM with variable-latency memory
//             handshake, illegal-opcode / timeout traps and instret counter.
//  Revision : 1.0  initial release
// ============================================================================
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TIMEOUT_W   = 8,
  parameter int CNT_W       = 32
) (
  input wire                   clk,
  input wire                   rst,
  multicycle_control_if.master bus
);

  localparam logic [2:0] c_s_fetch     = 3'd0;
  localparam logic [2:0] c_s_decode    = 3'd1;
  localparam logic [2:0] c_s_execute   = 3'd2;
  localparam logic [2:0] c_s_mem       = 3'd3;
  localparam logic [2:0] c_s_writeback = 3'd4;
  localparam logic [2:0] c_s_trap      = 3'd7;

  localparam logic [6:0] c_opc_r      = 7'b0110011;
  localparam logic [6:0] c_opc_i      = 7'b0010011;
  localparam logic [6:0] c_opc_load   = 7'b0000011;
  localparam logic [6:0] c_opc_store  = 7'b0100011;
  localparam logic [6:0] c_opc_lui    = 7'b0110111;
  localparam logic [6:0] c_opc_auipc  = 7'b0010111;
  localparam logic [6:0] c_opc_jal    = 7'b1101111;
  localparam logic [6:0] c_opc_jalr   = 7'b1100111;
  localparam logic [6:0] c_opc_branch = 7'b1100011;

  logic [2:0]           r_state;
  logic [2:0]           w_state_next;
  logic [TIMEOUT_W-1:0] r_wait;
  logic [CNT_W-1:0]     r_instret;
  logic                 r_illegal;
  logic                 r_timeout;

  logic w_is_r, w_is_i, w_is_load, w_is_store, w_is_lui, w_is_auipc;
  logic w_is_jal, w_is_jalr, w_is_branch, w_legal;
  logic w_wait_phase, w_timeout_hit;

  logic       w_imem_req, w_ir_write, w_dmem_req, w_dmem_write;
  logic       w_regfile_write, w_pc_write, w_imm_alu_sel;
  logic [1:0] w_pc_sel;
  logic [2:0] w_data_sel;

  // Opcode classification
  always_comb begin
    w_is_r      = (bus.opcode == c_opc_r);
    w_is_i      = (bus.opcode == c_opc_i);
    w_is_load   = (bus.opcode == c_opc_load);
    w_is_store  = (bus.opcode == c_opc_store);
    w_is_lui    = (bus.opcode == c_opc_lui);
    w_is_auipc  = (bus.opcode == c_opc_auipc);
    w_is_jal    = (bus.opcode == c_opc_jal);
    w_is_jalr   = (bus.opcode == c_opc_jalr);
    w_is_branch = (bus.opcode == c_opc_branch);
    w_legal     = w_is_r | w_is_i | w_is_load | w_is_store | w_is_lui |
                  w_is_auipc | w_is_jal | w_is_jalr | w_is_branch;
  end

  assign w_wait_phase = ((r_state == c_s_fetch) && !bus.imem_ready) ||
                        ((r_state == c_s_mem)   && !bus.dmem_ready);

  // The limit is hit on the waiting cycle that would take the counter to
  // MEM_TIMEOUT; a ready in that same cycle keeps w_wait_phase low.
  if (MEM_TIMEOUT != 0) begin : g_timeout
    localparam logic [TIMEOUT_W-1:0] c_limit = TIMEOUT_W'(MEM_TIMEOUT - 1);
    assign w_timeout_hit = w_wait_phase && (r_wait == c_limit);
  end else begin : g_no_timeout
    assign w_timeout_hit = 1'b0;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_s_fetch;
    else     r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_s_fetch: begin
        if (bus.imem_ready)     w_state_next = c_s_decode;
        else if (w_timeout_hit) w_state_next = c_s_trap;
      end
      c_s_decode:
        w_state_next = w_legal ? c_s_execute : c_s_trap;
      c_s_execute: begin
        if (w_is_load || w_is_store) w_state_next = c_s_mem;
        else if (w_is_branch)        w_state_next = c_s_fetch;
        else                         w_state_next = c_s_writeback;
      end
      c_s_mem: begin
        if (bus.dmem_ready)     w_state_next = w_is_store ? c_s_fetch : c_s_writeback;
        else if (w_timeout_hit) w_state_next = c_s_trap;
      end
      c_s_writeback:
        w_state_next = c_s_fetch;
      c_s_trap:
        w_state_next = c_s_trap;
      default:
        w_state_next = c_s_fetch;
    endcase
  end

  // Output logic
  always_comb begin
    w_imem_req      = 1'b0;
    w_ir_write      = 1'b0;
    w_dmem_req      = 1'b0;
    w_dmem_write    = 1'b0;
    w_regfile_write = 1'b0;
    w_pc_write      = 1'b0;
    w_pc_sel        = 2'd0;
    w_data_sel      = 3'd0;
    w_imm_alu_sel   = 1'b0;
    case (r_state)
      c_s_fetch: begin
        w_imem_req = 1'b1;
        w_ir_write = bus.imem_ready;
      end
      c_s_execute:
        w_pc_write = w_is_branch;
      c_s_mem: begin
        w_dmem_req   = 1'b1;
        w_dmem_write = w_is_store;
        w_pc_write   = w_is_store && bus.dmem_ready;
      end
      c_s_writeback: begin
        w_regfile_write = 1'b1;
        w_pc_write      = 1'b1;
      end
      default: ;
    endcase
    if ((r_state == c_s_execute) || (r_state == c_s_mem) || (r_state == c_s_writeback)) begin
      if (w_is_jal)                          w_pc_sel = 2'd1;
      else if (w_is_jalr)                    w_pc_sel = 2'd2;
      else if (w_is_branch && bus.branch_comp) w_pc_sel = 2'd3;
      if (w_is_load)                     w_data_sel = 3'd1;
      else if (w_is_jal || w_is_jalr)    w_data_sel = 3'd2;
      else if (w_is_lui)                 w_data_sel = 3'd3;
      else if (w_is_auipc)               w_data_sel = 3'd4;
      w_imm_alu_sel = w_is_i | w_is_load | w_is_store | w_is_jalr;
    end
  end

  // Wait counter saturates so a disabled timeout never wraps back to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   r_wait <= '0;
    else if (!w_wait_phase)    r_wait <= '0;
    else if (r_wait != '1)     r_wait <= r_wait + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_instret <= '0;
    else if (w_pc_write) r_instret <= r_instret + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if ((r_state == c_s_decode) && !w_legal) r_illegal <= 1'b1;
      if (w_timeout_hit)                       r_timeout <= 1'b1;
    end
  end

  // Strobes are forced low while reset is held so an aborted access drops at once
  assign bus.imem_req                = w_imem_req      & ~rst;
  assign bus.ir_write                = w_ir_write      & ~rst;
  assign bus.dmem_req                = w_dmem_req      & ~rst;
  assign bus.dmem_write              = w_dmem_write    & ~rst;
  assign bus.regfile_write           = w_regfile_write & ~rst;
  assign bus.pc_write                = w_pc_write      & ~rst;
  assign bus.pc_next_address_sel     = rst ? 2'd0 : w_pc_sel;
  assign bus.regfile_data_source_sel = rst ? 3'd0 : w_data_sel;
  assign bus.imm_alu_sel             = w_imm_alu_sel   & ~rst;
  assign bus.illegal_insn            = r_illegal;
  assign bus.timeout                 = r_timeout;
  assign bus.state                   = r_state;
  assign bus.instret                 = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_control
//  Purpose  : Directed scoreboard bench for the multi-cycle control FSM.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_control;

  typedef struct packed {
    logic [2:0]  state;
    logic [5:0]  strb;   // imem_req, ir_write, dmem_req, dmem_write, regfile_write, pc_write
    logic [1:0]  pcs;
    logic [2:0]  ds;
    logic        imm;
    logic        ill;
    logic        to;
    logic [31:0] instret;
  } rec_t;

  logic clk;
  logic rst;

  multicycle_control_if #(.CNT_W(32)) bus ();

  multicycle_control #(
    .MEM_TIMEOUT(4),
    .TIMEOUT_W  (8),
    .CNT_W      (32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  rec_t        sb[$];
  string       tags[$];
  rec_t        exp_r;
  rec_t        obs_r;
  string       tag_r;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] e_instret = '0;
  logic        e_ill = 1'b0;
  logic        e_to = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard checker: one expected record per cycle, compared mid low phase
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_r = sb.pop_front();
      tag_r = tags.pop_front();
      obs_r = '{bus.state,
                {bus.imem_req, bus.ir_write, bus.dmem_req, bus.dmem_write,
                 bus.regfile_write, bus.pc_write},
                bus.pc_next_address_sel, bus.regfile_data_source_sel,
                bus.imm_alu_sel, bus.illegal_insn, bus.timeout, bus.instret};
      checks++;
      assert (obs_r === exp_r) else begin
        errors++;
        $error("FAIL %s observed %h expected %h", tag_r, obs_r, exp_r);
      end
    end
  end

  task automatic cyc(input string tag, input logic [2:0] st, input logic [5:0] strb,
                     input logic [1:0] pcs, input logic [2:0] ds, input logic imm);
    rec_t e;
    e = '{st, strb, pcs, ds, imm, e_ill, e_to, e_instret};
    sb.push_back(e);
    tags.push_back(tag);
    @(posedge clk);
    #1;
    if (strb[0]) e_instret = e_instret + 1;
  endtask

  task automatic fetch_decode(input logic [6:0] op);
    bus.opcode     = op;
    bus.imem_ready = 1'b1;
    cyc("fetch", 3'd0, 6'b110000, 2'd0, 3'd0, 1'b0);
    bus.imem_ready = 1'b0;
    cyc("decode", 3'd1, 6'b000000, 2'd0, 3'd0, 1'b0);
  endtask

  task automatic reset_pulse();
    rst       = 1'b1;
    e_instret = '0;
    e_ill     = 1'b0;
    e_to      = 1'b0;
    cyc("reset", 3'd0, 6'b000000, 2'd0, 3'd0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    bus.opcode      = 7'b0;
    bus.branch_comp = 1'b0;
    bus.imem_ready  = 1'b0;
    bus.dmem_ready  = 1'b0;
    @(posedge clk);
    #1;
    reset_pulse();

    // addi
    fetch_decode(7'b0010011);
    cyc("addi_ex", 3'd2, 6'b000000, 2'd0, 3'd0, 1'b1);
    cyc("addi_wb", 3'd4, 6'b000011, 2'd0, 3'd0, 1'b1);

    // lw, two wait cycles then ready
    fetch_decode(7'b0000011);
    cyc("lw_ex", 3'd2, 6'b000000, 2'd0, 3'd1, 1'b1);
    cyc("lw_mem_w1", 3'd3, 6'b001000, 2'd0, 3'd1, 1'b1);
    cyc("lw_mem_w2", 3'd3, 6'b001000, 2'd0, 3'd1, 1'b1);
    bus.dmem_ready = 1'b1;
    cyc("lw_mem_rdy", 3'd3, 6'b001000, 2'd0, 3'd1, 1'b1);
    bus.dmem_ready = 1'b0;
    cyc("lw_wb", 3'd4, 6'b000011, 2'd0, 3'd1, 1'b1);

    // sw, zero-wait
    fetch_decode(7'b0100011);
    cyc("sw_ex", 3'd2, 6'b000000, 2'd0, 3'd0, 1'b1);
    bus.dmem_ready = 1'b1;
    cyc("sw_mem", 3'd3, 6'b001101, 2'd0, 3'd0, 1'b1);
    bus.dmem_ready = 1'b0;

    // beq taken then not taken
    fetch_decode(7'b1100011);
    bus.branch_comp = 1'b1;
    cyc("beq_taken", 3'd2, 6'b000001, 2'd3, 3'd0, 1'b0);
    bus.branch_comp = 1'b0;
    fetch_decode(7'b1100011);
    cyc("beq_not", 3'd2, 6'b000001, 2'd0, 3'd0, 1'b0);

    // jal, jalr
    fetch_decode(7'b1101111);
    cyc("jal_ex", 3'd2, 6'b000000, 2'd1, 3'd2, 1'b0);
    cyc("jal_wb", 3'd4, 6'b000011, 2'd1, 3'd2, 1'b0);
    fetch_decode(7'b1100111);
    cyc("jalr_ex", 3'd2, 6'b000000, 2'd2, 3'd2, 1'b1);
    cyc("jalr_wb", 3'd4, 6'b000011, 2'd2, 3'd2, 1'b1);

    // lui, auipc, R-type
    fetch_decode(7'b0110111);
    cyc("lui_ex", 3'd2, 6'b000000, 2'd0, 3'd3, 1'b0);
    cyc("lui_wb", 3'd4, 6'b000011, 2'd0, 3'd3, 1'b0);
    fetch_decode(7'b0010111);
    cyc("auipc_ex", 3'd2, 6'b000000, 2'd0, 3'd4, 1'b0);
    cyc("auipc_wb", 3'd4, 6'b000011, 2'd0, 3'd4, 1'b0);

    // Fetch with ready exactly on the 4th cycle: no trap
    bus.opcode = 7'b0110011;
    for (int i = 0; i < 3; i++) cyc("fetch_wait", 3'd0, 6'b100000, 2'd0, 3'd0, 1'b0);
    bus.imem_ready = 1'b1;
    cyc("fetch_rdy4", 3'd0, 6'b110000, 2'd0, 3'd0, 1'b0);
    bus.imem_ready = 1'b0;
    cyc("r_dec", 3'd1, 6'b000000, 2'd0, 3'd0, 1'b0);
    cyc("r_ex", 3'd2, 6'b000000, 2'd0, 3'd0, 1'b0);
    cyc("r_wb", 3'd4, 6'b000011, 2'd0, 3'd0, 1'b0);

    // lw with data ready exactly on the 4th MEM cycle: no trap
    fetch_decode(7'b0000011);
    cyc("lw4_ex", 3'd2, 6'b000000, 2'd0, 3'd1, 1'b1);
    for (int i = 0; i < 3; i++) cyc("lw4_mem_w", 3'd3, 6'b001000, 2'd0, 3'd1, 1'b1);
    bus.dmem_ready = 1'b1;
    cyc("lw4_mem_rdy", 3'd3, 6'b001000, 2'd0, 3'd1, 1'b1);
    bus.dmem_ready = 1'b0;
    cyc("lw4_wb", 3'd4, 6'b000011, 2'd0, 3'd1, 1'b1);

    // Reset in the middle of a MEM wait
    fetch_decode(7'b0000011);
    cyc("lwr_ex", 3'd2, 6'b000000, 2'd0, 3'd1, 1'b1);
    cyc("lwr_mem", 3'd3, 6'b001000, 2'd0, 3'd1, 1'b1);
    reset_pulse();

    // Fetch timeout: four waiting cycles then TRAP
    for (int i = 0; i < 4; i++) cyc("to_wait", 3'd0, 6'b100000, 2'd0, 3'd0, 1'b0);
    e_to = 1'b1;
    cyc("to_trap", 3'd7, 6'b000000, 2'd0, 3'd0, 1'b0);
    bus.imem_ready = 1'b1;
    cyc("to_trap_hold", 3'd7, 6'b000000, 2'd0, 3'd0, 1'b0);
    bus.imem_ready = 1'b0;
    reset_pulse();

    // Illegal opcode trap, absorbing
    fetch_decode(7'b0000000);
    e_ill = 1'b1;
    cyc("ill_trap", 3'd7, 6'b000000, 2'd0, 3'd0, 1'b0);
    bus.opcode     = 7'b0010011;
    bus.imem_ready = 1'b1;
    cyc("ill_hold", 3'd7, 6'b000000, 2'd0, 3'd0, 1'b0);
    bus.imem_ready = 1'b0;
    reset_pulse();

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
